// File: rtl/cpu_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package cpu_arb_pkg;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and shared-port signals of the memory-port arbiter.
// slave: arbiter view; master: requesters plus memory port view.
interface mem_port_arbiter_if;
    import cpu_arb_pkg::*;

    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic [DW-1:0] inst_rdata;

    logic          data_req;
    logic          data_wr;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic [SW-1:0] data_wstrb;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [DW-1:0] data_rdata;

    logic          bus_req;
    logic          bus_wr;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [SW-1:0] bus_wstrb;
    logic          bus_addr_ok;
    logic          bus_data_ok;
    logic [DW-1:0] bus_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_addr, data_wdata, data_wstrb,
        output data_addr_ok, data_data_ok, data_rdata,
        output bus_req, bus_wr, bus_addr, bus_wdata, bus_wstrb,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_addr, data_wdata, data_wstrb,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  bus_req, bus_wr, bus_addr, bus_wdata, bus_wstrb,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Grant decision for the memory-port arbiter.
// ARB_ROUND_ROBIN_EN: alternate owners on conflict using last_data.
module arb_pick
    import cpu_arb_pkg::*;
(
    input  logic inst_req,
    input  logic data_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_data,
`endif
    output logic pick_data_c
);

    // A lone requester wins; on conflict data wins, or the side not granted last
    always_comb begin
        pick_data_c = (inst_req && !data_req) ? OWN_INST : OWN_DATA;
`ifdef ARB_ROUND_ROBIN_EN
        if (inst_req && data_req) begin
            pick_data_c = last_data ? OWN_INST : OWN_DATA;
        end
`endif
    end

endmodule

// File: rtl/mux2.sv
// Generic 2:1 multiplexer; s=1 selects b.
module mux2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between fetch and data requesters,
// one transaction in flight at a time (IDLE -> ADDR -> DATA).
// ARB_ROUND_ROBIN_EN: round-robin arbitration on conflict instead of
// fixed data-over-inst priority.
module mem_port_arbiter
    import cpu_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   port,
    output logic                grant_data
);

    arb_state_e    state_q, state_d;
    logic          grant_q, grant_d;
    logic          pick_data_c;
    logic          bus_req_c;
    logic          addr_ok_c;
    logic          data_ok_c;
    logic          sel_wr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [SW-1:0] sel_wstrb;

`ifdef ARB_ROUND_ROBIN_EN
    logic          last_data_q, last_data_d;
`endif

    arb_pick u_pick (
        .inst_req    (port.inst_req),
        .data_req    (port.data_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_data   (last_data_q),
`endif
        .pick_data_c (pick_data_c)
    );

    // State, grant and round-robin history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            grant_q     <= OWN_INST;
`ifdef ARB_ROUND_ROBIN_EN
            last_data_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_data_q <= last_data_d;
`endif
        end
    end

    // Next state, grant latch and un-routed handshake strobes
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_data_d = last_data_q;
`endif
        bus_req_c   = 1'b0;
        addr_ok_c   = 1'b0;
        data_ok_c   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (port.inst_req || port.data_req) begin
                    grant_d     = pick_data_c;
`ifdef ARB_ROUND_ROBIN_EN
                    last_data_d = pick_data_c;
`endif
                    state_d     = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                bus_req_c = 1'b1;
                addr_ok_c = port.bus_addr_ok;
                if (port.bus_addr_ok) begin
                    state_d = ARB_DATA;
                end
            end
            ARB_DATA: begin
                data_ok_c = port.bus_data_ok;
                if (port.bus_data_ok) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Owner request select; the fetch side never writes
    mux2 #(.WIDTH(AW)) u_mux_addr  (.a(port.inst_addr), .b(port.data_addr),  .s(grant_q), .y(sel_addr));
    mux2 #(.WIDTH(DW)) u_mux_wdata (.a('0),             .b(port.data_wdata), .s(grant_q), .y(sel_wdata));
    mux2 #(.WIDTH(SW)) u_mux_wstrb (.a('0),             .b(port.data_wstrb), .s(grant_q), .y(sel_wstrb));
    mux2 #(.WIDTH(1))  u_mux_wr    (.a(1'b0),           .b(port.data_wr),    .s(grant_q), .y(sel_wr));

    // Bus request fields are zero unless a request is being presented
    assign port.bus_req      = bus_req_c;
    assign port.bus_wr       = bus_req_c & sel_wr;
    assign port.bus_addr     = bus_req_c ? sel_addr  : '0;
    assign port.bus_wdata    = bus_req_c ? sel_wdata : '0;
    assign port.bus_wstrb    = bus_req_c ? sel_wstrb : '0;

    // Handshakes go to the owner only; read data is shared
    assign port.inst_addr_ok = addr_ok_c & (grant_q == OWN_INST);
    assign port.data_addr_ok = addr_ok_c & (grant_q == OWN_DATA);
    assign port.inst_data_ok = data_ok_c & (grant_q == OWN_INST);
    assign port.data_data_ok = data_ok_c & (grant_q == OWN_DATA);
    assign port.inst_rdata   = port.bus_rdata;
    assign port.data_rdata   = port.bus_rdata;

    assign grant_data        = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of per-cycle vectors plus a
// round-robin conflict sequence when ARB_ROUND_ROBIN_EN is defined.
module tb_mem_port_arbiter;
    import cpu_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic grant_data;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if bus_if ();

    mem_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .port       (bus_if),
        .grant_data (grant_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwr;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [3:0]  dstrb;
        logic        baok;
        logic        bdok;
        logic [31:0] brdata;
        logic        grant;
        logic        breq;
        logic        bwr;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [3:0]  bstrb;
        logic [3:0]  oks;     // {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic ireq, input logic [31:0] iaddr,
        input logic dreq, input logic dwr, input logic [31:0] daddr,
        input logic [31:0] dwdata, input logic [3:0] dstrb,
        input logic baok, input logic bdok, input logic [31:0] brdata,
        input logic grant, input logic breq, input logic bwr,
        input logic [31:0] baddr, input logic [31:0] bwdata,
        input logic [3:0] bstrb, input logic [3:0] oks);
        vec_t v;
        v.rst = r;      v.ireq = ireq;   v.iaddr = iaddr;
        v.dreq = dreq;  v.dwr = dwr;     v.daddr = daddr;
        v.dwdata = dwdata; v.dstrb = dstrb;
        v.baok = baok;  v.bdok = bdok;   v.brdata = brdata;
        v.grant = grant; v.breq = breq;  v.bwr = bwr;
        v.baddr = baddr; v.bwdata = bwdata; v.bstrb = bstrb;
        v.oks = oks;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %h, expected %h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst                = v.rst;
        bus_if.inst_req    = v.ireq;
        bus_if.inst_addr   = v.iaddr;
        bus_if.data_req    = v.dreq;
        bus_if.data_wr     = v.dwr;
        bus_if.data_addr   = v.daddr;
        bus_if.data_wdata  = v.dwdata;
        bus_if.data_wstrb  = v.dstrb;
        bus_if.bus_addr_ok = v.baok;
        bus_if.bus_data_ok = v.bdok;
        bus_if.bus_rdata   = v.brdata;
    endtask

    function automatic logic [3:0] oks_now();
        return {bus_if.inst_addr_ok, bus_if.inst_data_ok, bus_if.data_addr_ok, bus_if.data_data_ok};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] A, R, W, L, F8, C, E;
        A = 32'hBFC0_0000; R = 32'h2408_0001; W = 32'h8000_0020;
        L = 32'h8000_0040; F8 = 32'hBFC0_0008; C = 32'h8000_0010; E = 32'hBFC0_0004;

        drive(mk(1, 0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,4'b0000));

        // reset state
        vecs.push_back(mk(1, 0,0, 0,0,0,0,0, 0,0,0,          0,0,0,0,0,0,4'b0000));
        // lone fetch
        vecs.push_back(mk(0, 1,A, 0,0,0,0,0, 0,0,0,          0,0,0,0,0,0,4'b0000));
        vecs.push_back(mk(0, 1,A, 0,0,0,0,0, 1,0,0,          0,1,0,A,0,0,4'b1000));
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 0,1,R,          0,0,0,0,0,0,4'b0100));
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 0,0,0,          0,0,0,0,0,0,4'b0000));
        // spurious strobes in IDLE, then data_ok in ADDR
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 1,1,32'h1111_1111, 0,0,0,0,0,0,4'b0000));
        vecs.push_back(mk(0, 1,A, 0,0,0,0,0, 0,0,0,          0,0,0,0,0,0,4'b0000));
        vecs.push_back(mk(0, 1,A, 0,0,0,0,0, 0,1,0,          0,1,0,A,0,0,4'b0000));
        vecs.push_back(mk(0, 1,A, 0,0,0,0,0, 1,0,0,          0,1,0,A,0,0,4'b1000));
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 0,1,32'h3C1D_8000, 0,0,0,0,0,0,4'b0100));
        // store with wait states: addr_ok after 3 waits, data_ok after 2 more
        vecs.push_back(mk(0, 0,0, 1,1,W,32'h1234_5678,4'h3, 0,0,0, 0,0,0,0,0,0,4'b0000));
        vecs.push_back(mk(0, 0,0, 1,1,W,32'h1234_5678,4'h3, 0,0,0, 1,1,1,W,32'h1234_5678,4'h3,4'b0000));
        vecs.push_back(mk(0, 0,0, 1,1,W,32'h1234_5678,4'h3, 0,0,0, 1,1,1,W,32'h1234_5678,4'h3,4'b0000));
        vecs.push_back(mk(0, 0,0, 1,1,W,32'h1234_5678,4'h3, 0,0,0, 1,1,1,W,32'h1234_5678,4'h3,4'b0000));
        vecs.push_back(mk(0, 0,0, 1,1,W,32'h1234_5678,4'h3, 1,0,0, 1,1,1,W,32'h1234_5678,4'h3,4'b0010));
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 0,0,0,          1,0,0,0,0,0,4'b0000));
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 0,0,0,          1,0,0,0,0,0,4'b0000));
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 0,1,0,          1,0,0,0,0,0,4'b0001));
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 0,0,0,          1,0,0,0,0,0,4'b0000));
        // load abandoned by reset in DATA, late data_ok ignored, next fetch normal
        vecs.push_back(mk(0, 0,0, 1,0,L,0,0, 0,0,0,          1,0,0,0,0,0,4'b0000));
        vecs.push_back(mk(0, 0,0, 1,0,L,0,0, 1,0,0,          1,1,0,L,0,0,4'b0010));
        vecs.push_back(mk(1, 0,0, 0,0,0,0,0, 0,0,0,          1,0,0,0,0,0,4'b0000));
        vecs.push_back(mk(0, 1,F8, 0,0,0,0,0, 0,1,32'h5555, 0,0,0,0,0,0,4'b0000));
        vecs.push_back(mk(0, 1,F8, 0,0,0,0,0, 1,0,0,         0,1,0,F8,0,0,4'b1000));
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 0,1,32'h8C02_0000, 0,0,0,0,0,0,4'b0100));
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 0,0,0,          0,0,0,0,0,0,4'b0000));
`ifndef ARB_ROUND_ROBIN_EN
        // conflict: store wins, fetch served in the next transaction
        vecs.push_back(mk(0, 1,E, 1,1,C,32'hDEAD_BEEF,4'hF, 0,0,0, 0,0,0,0,0,0,4'b0000));
        vecs.push_back(mk(0, 1,E, 1,1,C,32'hDEAD_BEEF,4'hF, 1,0,0, 1,1,1,C,32'hDEAD_BEEF,4'hF,4'b0010));
        vecs.push_back(mk(0, 1,E, 0,0,0,0,0, 0,1,0,          1,0,0,0,0,0,4'b0001));
        vecs.push_back(mk(0, 1,E, 0,0,0,0,0, 0,0,0,          1,0,0,0,0,0,4'b0000));
        vecs.push_back(mk(0, 1,E, 0,0,0,0,0, 1,0,0,          0,1,0,E,0,0,4'b1000));
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 0,1,32'h42,     0,0,0,0,0,0,4'b0100));
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 0,0,0,          0,0,0,0,0,0,4'b0000));
`endif

        @(posedge clk);
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            @(negedge clk);
            chk("grant_data", i, 64'(grant_data),        64'(vecs[i].grant));
            chk("bus_req",    i, 64'(bus_if.bus_req),    64'(vecs[i].breq));
            chk("bus_wr",     i, 64'(bus_if.bus_wr),     64'(vecs[i].bwr));
            chk("bus_addr",   i, 64'(bus_if.bus_addr),   64'(vecs[i].baddr));
            chk("bus_wdata",  i, 64'(bus_if.bus_wdata),  64'(vecs[i].bwdata));
            chk("bus_wstrb",  i, 64'(bus_if.bus_wstrb),  64'(vecs[i].bstrb));
            chk("ok_strobes", i, 64'(oks_now()),         64'(vecs[i].oks));
            chk("inst_rdata", i, 64'(bus_if.inst_rdata), 64'(vecs[i].brdata));
            chk("data_rdata", i, 64'(bus_if.data_rdata), 64'(vecs[i].brdata));
        end

`ifdef ARB_ROUND_ROBIN_EN
        begin
            logic exp_order [4];
            exp_order[0] = 1'b0; exp_order[1] = 1'b1;
            exp_order[2] = 1'b0; exp_order[3] = 1'b1;
            @(posedge clk);
            #1;
            drive(mk(1, 0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,4'b0000));
            @(posedge clk);
            #1;
            drive(mk(0, 1,E, 1,0,C,0,0, 0,0,0, 0,0,0,0,0,0,4'b0000));
            for (int t = 0; t < 4; t++) begin
                @(negedge clk);
                chk("rr_idle_bus_req", 100 + t, 64'(bus_if.bus_req), 64'(0));
                @(posedge clk);
                #1;
                bus_if.bus_addr_ok = 1'b1;
                @(negedge clk);
                chk("rr_grant",    100 + t, 64'(grant_data), 64'(exp_order[t]));
                chk("rr_bus_addr", 100 + t, 64'(bus_if.bus_addr), exp_order[t] ? 64'(C) : 64'(E));
                chk("rr_addr_ok",  100 + t, 64'({bus_if.inst_addr_ok, bus_if.data_addr_ok}),
                    64'({~exp_order[t], exp_order[t]}));
                @(posedge clk);
                #1;
                bus_if.bus_addr_ok = 1'b0;
                bus_if.bus_data_ok = 1'b1;
                @(negedge clk);
                chk("rr_data_ok",  100 + t, 64'({bus_if.inst_data_ok, bus_if.data_data_ok}),
                    64'({~exp_order[t], exp_order[t]}));
                @(posedge clk);
                #1;
                bus_if.bus_data_ok = 1'b0;
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single SRAM-like memory port between the instruction-fetch requester and the data-access (MEM stage) requester. One transaction is in flight at a time. A three-state FSM latches the grant, presents the owner's request on the shared bus, and routes the address-accept and data-return handshakes back to the owner only. The bus address/write path is selected by the codebase's 2:1 `mux2`, and its select is driven by the registered grant.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `clk` in 1, sole clock, rising edge
- `rst` in 1, synchronous, active-high reset
- `inst_req` in 1, fetch request; held until `inst_addr_ok`
- `inst_addr` in AW, fetch address; stable while `inst_req`
- `inst_addr_ok` out 1, fetch address accepted (1-cycle pulse)
- `inst_data_ok` out 1, fetch data valid (1-cycle pulse)
- `inst_rdata` out DW, fetch read data; valid with `inst_data_ok`
- `data_req` in 1, load/store request; held until `data_addr_ok`
- `data_wr` in 1, 1 = store
- `data_addr` in AW, load/store address
- `data_wdata` in DW, store data
- `data_wstrb` in DW/8, byte enables
- `data_addr_ok` out 1, load/store address accepted (pulse)
- `data_data_ok` out 1, load done / store acknowledged (pulse)
- `data_rdata` out DW, load data; valid with `data_data_ok`
- `bus_req` out 1, shared-port request
- `bus_wr` out 1, shared-port write
- `bus_addr` out AW, shared-port address
- `bus_wdata` out DW, shared-port write data
- `bus_wstrb` out DW/8, shared-port byte enables
- `bus_addr_ok` in 1, port accepted request
- `bus_data_ok` in 1, port returned data / write ack
- `bus_rdata` in DW, port read data
- `grant_data` out 1, registered owner: 0 = inst, 1 = data

## Operation
- **States.** IDLE → ADDR → DATA → IDLE.
- **IDLE.**
  - `bus_req`=0.
  - If either request is high, latch the owner per the arbitration policy into `grant_data`; next state is ADDR.
  - With no request, stay in IDLE.
- **ADDR.**
  - `bus_req`=1.
  - `bus_wr`, `bus_addr`, `bus_wdata`, `bus_wstrb` come from the owner, selected by `grant_data`. The inst side drives `wr`=0, `wdata`=0, `wstrb`=0.
  - The owner's `*_addr_ok` = `bus_addr_ok`; the non-owner's is 0.
  - On `bus_addr_ok` go to DATA.
- **DATA.**
  - `bus_req`=0.
  - The owner's `*_data_ok` = `bus_data_ok`.
  - On `bus_data_ok` go to IDLE.
- **Default arbitration.** Fixed priority, data over inst. When both request in IDLE, data wins.
- **Read data.** `inst_rdata` and `data_rdata` are both wired to `bus_rdata` at all times. The `*_data_ok` strobes qualify them.
- **Gating.** `bus_addr_ok` is ignored outside ADDR, and `bus_data_ok` is ignored outside DATA. Neither produces a pulse or a state change.
- **Requester protocol.** A requester never drops `*_req` between assertion and its `*_addr_ok`. Behaviour on a violation is undefined, and the bench does not exercise it.
- **Reset values.**
  - State = IDLE, `grant_data`=0.
  - `bus_req`=0; all `*_addr_ok` and `*_data_ok` = 0.
  - `bus_addr`, `bus_wdata`, `bus_wstrb`, `bus_wr` = 0.
- **Reset mid-transaction.** The FSM returns to IDLE at that edge, the in-flight transaction is abandoned, and no `ok` pulse is issued. The memory port shares `rst`.

## Timing
- Handshake outputs are combinational from state, `grant_data` and the bus inputs. State and grant are registered.
- **Minimum transaction, request first seen in IDLE at cycle 0:**
  - Cycle 1: ADDR, `bus_req`=1; earliest `addr_ok`.
  - Cycle 2: DATA; earliest `data_ok`.
  - Cycle 3: IDLE; a new grant may latch.
  - Cycle 4: next `bus_req`.
- Peak throughput is one transaction per 3 cycles.
- Bus wait states stretch ADDR and DATA indefinitely. No timeout.
- `bus_data_ok` is never expected in the same cycle as `bus_addr_ok`.

## Configuration
- Macro `ARB_ROUND_ROBIN_EN`.
- **Defined.**
  - Adds a `last_data` register, reset to 1.
  - When both requesters are high in IDLE, grant goes to the side not granted last. The first conflict after reset goes to inst.
  - `last_data` updates on every transition from IDLE to ADDR.
  - A single requester is always granted immediately.
- **Undefined.** Fixed data-over-inst priority and no `last_data` register.

## Structure
- **Shared package/header `cpu_arb_pkg`:**
  - State encodings: `ARB_IDLE`=2'd0, `ARB_ADDR`=2'd1, `ARB_DATA`=2'd2.
  - Owner constants: `OWN_INST`=1'b0, `OWN_DATA`=1'b1.
- **Sub-modules.**
  - `mux2` instances with `WIDTH`=AW, DW, DW/8 and 1 form the bus-side request select, with `s`=`grant_data` (s=1 selects data).
  - `arb_pick` is the one natural sub-module: combinational grant decision from the two requests and `last_data`.

## Test plan
- **Lone fetch.** `inst_req`=1, `inst_addr`=0xBFC00000, `bus_addr_ok` at cycle 1, `bus_data_ok` with `bus_rdata`=0x24080001 at cycle 2 → `bus_addr`=0xBFC00000 in cycle 1, `inst_addr_ok` pulse cycle 1, `inst_data_ok` cycle 2 with `inst_rdata`=0x24080001, `data_*_ok` never high.
- **Conflict, default build.** Both requests in the same IDLE cycle; store `data_addr`=0x80000010, `wdata`=0xDEADBEEF, `wstrb`=4'hF → `grant_data`=1, `bus_wr`=1 first; the fetch is served in the following transaction.
- **Conflict, `ARB_ROUND_ROBIN_EN`.** Both requests held continuously for 4 transactions → grant order is inst, data, inst, data.
- **Wait states.** `bus_addr_ok` delayed 3 cycles, `bus_data_ok` 2 further cycles → `bus_req` held 4 cycles with stable address, exactly one `addr_ok` pulse and one `data_ok` pulse to the owner.
- **Spurious strobes.** `bus_data_ok`=1 in IDLE or ADDR → no `*_data_ok` pulse and no state change.
- **Reset mid-DATA.** `rst`=1 for one cycle during DATA → next cycle IDLE, `bus_req`=0, `grant_data`=0, no `ok` pulses; the following fetch completes normally.
